// File: rtl/video_pkg.sv
// Shared encodings and default timing for the video memory path.
package video_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      VRD  = 3'd1,
      CRD  = 3'd2,
      CWS  = 3'd3,
      CWP  = 3'd4,
      CWH  = 3'd5
   } state_t;

   localparam int RD_WAIT_DEF  = 1;
   localparam int WR_PULSE_DEF = 2;

endpackage

// File: rtl/vram_pending.sv
// One-entry latch for a video fetch that arrives while the SRAM is busy.
module vram_pending (
   input  logic        clk24,
   input  logic        reset,
   input  logic        capture,
   input  logic        take,
   input  logic [15:0] addr_in,
   output logic        vld,
   output logic [15:0] addr
);

   // Sticky: a second fetch replaced one still waiting.
   logic overrun;

   always_ff @(posedge clk24 or posedge reset) begin
      if (reset) begin
         vld     <= 1'b0;
         addr    <= '0;
         overrun <= 1'b0;
      end else if (capture) begin
         vld  <= 1'b1;
         addr <= addr_in;
         if (vld) overrun <= 1'b1;
      end else if (take) begin
         vld <= 1'b0;
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// SRAM owner: fixed-latency video byte reads, CPU reads/writes outside the video slice.
module vram_arbiter
   import video_pkg::*;
#(
   parameter int RD_WAIT  = RD_WAIT_DEF,
   parameter int WR_PULSE = WR_PULSE_DEF
) (
   input  logic        clk24,
   input  logic        reset,
   input  logic        video_slice,
   input  logic [15:0] video_addr,
   input  logic        video_req,
   output logic [7:0]  video_dq,
   output logic        video_valid,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic        cpu_ready,
   output logic [15:0] sram_addr,
   input  logic [7:0]  sram_dq_in,
   output logic [7:0]  sram_dq_out,
   output logic        sram_dq_oe,
   output logic        sram_oe_n,
   output logic        sram_we_n
);

   localparam logic [1:0] RD_CNT = 2'(RD_WAIT);
   localparam logic [1:0] WR_CNT = 2'(WR_PULSE - 1);

   state_t      state, state_nx;
   logic [1:0]  cnt, cnt_nx;
   logic [15:0] addr_nx;
   logic [7:0]  dq_out_nx, vdq_nx, cdout_nx;
   logic        oe_n_nx, we_n_nx, dq_oe_nx, vvalid_nx, cready_nx;
   logic        take_video;
   logic        pend_vld;
   logic [15:0] pend_addr;

   vram_pending u_pend (
      .clk24   (clk24),
      .reset   (reset),
      .capture (video_req && (state != IDLE)),
      .take    (take_video),
      .addr_in (video_addr),
      .vld     (pend_vld),
      .addr    (pend_addr)
   );

   // CPU is not accepted while cpu_ready is high: the request level is still
   // up for that cycle and would otherwise start a duplicate access.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      addr_nx    = sram_addr;
      dq_out_nx  = sram_dq_out;
      oe_n_nx    = sram_oe_n;
      we_n_nx    = 1'b1;
      dq_oe_nx   = sram_dq_oe;
      vdq_nx     = video_dq;
      cdout_nx   = cpu_dout;
      vvalid_nx  = 1'b0;
      cready_nx  = 1'b0;
      take_video = 1'b0;
      case (state)
         IDLE: begin
            oe_n_nx  = 1'b1;
            dq_oe_nx = 1'b0;
            if (pend_vld || video_req) begin
               take_video = 1'b1;
               state_nx   = VRD;
               addr_nx    = video_req ? video_addr : pend_addr;
               oe_n_nx    = 1'b0;
               cnt_nx     = RD_CNT;
            end else if (!video_slice && !cpu_ready && cpu_rd) begin
               state_nx = CRD;
               addr_nx  = cpu_addr;
               oe_n_nx  = 1'b0;
               cnt_nx   = RD_CNT;
            end else if (!video_slice && !cpu_ready && cpu_wr) begin
               state_nx  = CWS;
               addr_nx   = cpu_addr;
               dq_out_nx = cpu_din;
               dq_oe_nx  = 1'b1;
            end
         end
         VRD, CRD: begin
            if (cnt == 2'd0) begin
               state_nx = IDLE;
               oe_n_nx  = 1'b1;
               if (state == VRD) begin
                  vdq_nx    = sram_dq_in;
                  vvalid_nx = 1'b1;
               end else begin
                  cdout_nx  = sram_dq_in;
                  cready_nx = 1'b1;
               end
            end else begin
               cnt_nx = cnt - 2'd1;
            end
         end
         CWS: begin
            state_nx = CWP;
            we_n_nx  = 1'b0;
            cnt_nx   = WR_CNT;
         end
         CWP: begin
            if (cnt == 2'd0) begin
               state_nx = CWH;
            end else begin
               cnt_nx  = cnt - 2'd1;
               we_n_nx = 1'b0;
            end
         end
         CWH: begin
            state_nx  = IDLE;
            dq_oe_nx  = 1'b0;
            cready_nx = 1'b1;
         end
         default: begin
            state_nx = IDLE;
            oe_n_nx  = 1'b1;
            dq_oe_nx = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk24 or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
         sram_dq_oe  <= 1'b0;
         video_dq    <= '0;
         cpu_dout    <= '0;
         video_valid <= 1'b0;
         cpu_ready   <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         sram_addr   <= addr_nx;
         sram_dq_out <= dq_out_nx;
         sram_oe_n   <= oe_n_nx;
         sram_we_n   <= we_n_nx;
         sram_dq_oe  <= dq_oe_nx;
         video_dq    <= vdq_nx;
         cpu_dout    <= cdout_nx;
         video_valid <= vvalid_nx;
         cpu_ready   <= cready_nx;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural SRAM.
module tb_vram_arbiter;
   import video_pkg::*;

   logic        clk24 = 1'b0;
   logic        reset = 1'b1;
   logic        video_slice = 1'b0;
   logic [15:0] video_addr = '0;
   logic        video_req = 1'b0;
   logic [7:0]  video_dq;
   logic        video_valid;
   logic        cpu_rd = 1'b0;
   logic        cpu_wr = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_din = '0;
   logic [7:0]  cpu_dout;
   logic        cpu_ready;
   logic [15:0] sram_addr;
   logic [7:0]  sram_dq_in;
   logic [7:0]  sram_dq_out;
   logic        sram_dq_oe;
   logic        sram_oe_n;
   logic        sram_we_n;

   int vecs = 0;
   int errs = 0;
   int viol = 0;

   logic [7:0] mem [65536];
   logic       wv  [65536];

   vram_arbiter dut (
      .clk24       (clk24),
      .reset       (reset),
      .video_slice (video_slice),
      .video_addr  (video_addr),
      .video_req   (video_req),
      .video_dq    (video_dq),
      .video_valid (video_valid),
      .cpu_rd      (cpu_rd),
      .cpu_wr      (cpu_wr),
      .cpu_addr    (cpu_addr),
      .cpu_din     (cpu_din),
      .cpu_dout    (cpu_dout),
      .cpu_ready   (cpu_ready),
      .sram_addr   (sram_addr),
      .sram_dq_in  (sram_dq_in),
      .sram_dq_out (sram_dq_out),
      .sram_dq_oe  (sram_dq_oe),
      .sram_oe_n   (sram_oe_n),
      .sram_we_n   (sram_we_n)
   );

   always #20 clk24 = ~clk24;

   // Unwritten locations return fixed contents so reads need no preload.
   function automatic logic [7:0] pat(input logic [15:0] a);
      case (a)
         16'h8123: pat = 8'h5A;
         16'h2345: pat = 8'h3C;
         16'h9000: pat = 8'h77;
         16'h3000: pat = 8'h11;
         16'h8000: pat = 8'h10;
         16'hA000: pat = 8'h20;
         16'hC000: pat = 8'h30;
         16'hE000: pat = 8'h40;
         default:  pat = a[15:8] ^ a[7:0];
      endcase
   endfunction

   assign sram_dq_in = wv[sram_addr] ? mem[sram_addr] : pat(sram_addr);

   initial begin
      for (int i = 0; i < 65536; i++) wv[i] = 1'b0;
   end

   always @(negedge clk24) begin
      if (!sram_we_n && sram_dq_oe) begin
         mem[sram_addr] = sram_dq_out;
         wv[sram_addr]  = 1'b1;
      end
      if (!reset) begin
         if (!sram_oe_n && sram_dq_oe) viol++;
         if (!sram_we_n && !sram_dq_oe) viol++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk24);
      #1;
   endtask

   initial begin
      int oel, wel, nv, nr, v_at, r_at, oe_at, act;
      logic [15:0] va [4];
      logic [7:0]  vd [4];
      va = '{16'h8000, 16'hA000, 16'hC000, 16'hE000};
      vd = '{8'h10, 8'h20, 8'h30, 8'h40};

      // reset state
      repeat (3) step();
      chk("rst_oe_n", sram_oe_n, 1);
      chk("rst_we_n", sram_we_n, 1);
      chk("rst_dq_oe", sram_dq_oe, 0);
      chk("rst_addr", sram_addr, 0);
      reset = 1'b0;
      step();
      chk("rst_vdq", video_dq, 0);
      chk("rst_cdout", cpu_dout, 0);
      chk("rst_strobes", {video_valid, cpu_ready}, 0);

      // video only
      oel = 0; nv = 0; nr = 0; v_at = 0;
      video_addr = 16'h8123; video_req = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         video_req = 1'b0;
         if (i == 1) chk("v_addr", sram_addr, 16'h8123);
         if (!sram_oe_n) oel++;
         if (video_valid) begin nv++; v_at = i; end
         if (cpu_ready) nr++;
      end
      chk("v_oe_cycles", oel, 2);
      chk("v_valid_cnt", nv, 1);
      chk("v_latency", v_at, 3);
      chk("v_data", video_dq, 8'h5A);
      chk("v_no_ready", nr, 0);

      // CPU write
      wel = 0; nr = 0; r_at = 0; oe_at = 0;
      cpu_addr = 16'h1000; cpu_din = 8'hA5; cpu_wr = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (sram_dq_oe && oe_at == 0) oe_at = i;
         if (!sram_we_n) wel++;
         if (cpu_ready) begin nr++; r_at = i; cpu_wr = 1'b0; end
      end
      chk("w_dq_oe_at", oe_at, 1);
      chk("w_we_cycles", wel, 2);
      chk("w_ready_cnt", nr, 1);
      chk("w_ready_at", r_at, 5);
      chk("w_mem", {7'd0, wv[16'h1000], mem[16'h1000]}, {7'd0, 1'b1, 8'hA5});

      // CPU read blocked by video slice
      act = 0;
      video_slice = 1'b1; cpu_addr = 16'h2345; cpu_rd = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (!sram_oe_n || sram_dq_oe || cpu_ready) act++;
      end
      chk("s_blocked", act, 0);
      video_slice = 1'b0;
      step();
      chk("s_crd_start", {sram_oe_n, sram_addr}, {1'b0, 16'h2345});
      step();
      step();
      chk("s_ready", cpu_ready, 1);
      chk("s_dout", cpu_dout, 8'h3C);
      cpu_rd = 1'b0;
      step();
      chk("s_done", {cpu_ready, sram_oe_n}, 2'b01);

      // collision: video fetch arrives during a CPU write, CPU read queued behind
      nv = 0; nr = 0; v_at = 0; r_at = 0;
      cpu_addr = 16'h1234; cpu_din = 8'hC3; cpu_wr = 1'b1;
      step();
      step();
      video_addr = 16'h9000; video_req = 1'b1;
      for (int i = 3; i <= 14; i++) begin
         step();
         video_req = 1'b0;
         if (i == 6) chk("c_vrd_addr", {sram_oe_n, sram_addr}, {1'b0, 16'h9000});
         if (video_valid) begin nv++; v_at = i; end
         if (cpu_ready) begin
            nr++; r_at = i;
            if (cpu_wr) begin cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 16'h3000; end
            else cpu_rd = 1'b0;
         end
      end
      chk("c_mem", mem[16'h1234], 8'hC3);
      chk("c_valid_cnt", nv, 1);
      chk("c_valid_at", v_at - 2, 6);
      chk("c_vdata", video_dq, 8'h77);
      chk("c_ready_cnt", nr, 2);
      chk("c_rd_done_at", r_at, 11);
      chk("c_cdout", cpu_dout, 8'h11);

      // back-to-back plane fetches
      nv = 0;
      for (int i = 0; i < 15; i++) begin
         if (i % 3 == 0 && i < 12) begin
            video_req = 1'b1; video_addr = va[i / 3];
         end else video_req = 1'b0;
         step();
         if (video_valid) begin
            if (nv < 4) begin
               chk("b_data", video_dq, vd[nv]);
               chk("b_at", i + 1, 3 * (nv + 1));
            end
            nv++;
         end
      end
      chk("b_cnt", nv, 4);
      chk("b_overrun", dut.u_pend.overrun, 0);

      // reset mid-write with a video fetch pending
      cpu_addr = 16'h4000; cpu_din = 8'h99; cpu_wr = 1'b1;
      step();
      video_addr = 16'h5555; video_req = 1'b1;
      step();
      video_req = 1'b0;
      chk("r_in_cwp", {sram_we_n, sram_dq_oe}, 2'b01);
      chk("r_pending", dut.pend_vld, 1);
      #2 reset = 1'b1;
      cpu_wr = 1'b0;
      #1;
      chk("r_async", {sram_we_n, sram_dq_oe, sram_oe_n}, 3'b101);
      @(posedge clk24);
      @(posedge clk24);
      #1 reset = 1'b0;
      step();
      chk("r_pins", {sram_oe_n, sram_we_n, sram_dq_oe, sram_addr}, {3'b110, 16'h0});
      chk("r_data", {video_dq, cpu_dout, video_valid, cpu_ready}, 18'h0);
      chk("r_state", dut.state, IDLE);
      chk("r_pend_clr", dut.pend_vld, 0);
      nv = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (video_valid || !sram_oe_n) nv++;
      end
      chk("r_no_replay", nv, 0);
      chk("r_no_write", wv[16'h4000], 0);

      chk("pin_invariants", viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Memory-side responder for the video fetch path: owns the single external SRAM and serves framebuffer byte reads during video time slices.
- Serves CPU reads and writes in the remaining time, stalling the CPU with a ready flag while video owns the bus.
- Sits between the CPU bus, the framebuffer fetch port (address out, data in) and the physical SRAM pins.
- Every video read is answered with registered data at a fixed latency, so the framebuffer pipeline can rely on it.

Parameters:
- RD_WAIT, 1, number of extra clk24 cycles the SRAM address is held before read data is sampled (1..3).
- WR_PULSE, 2, width of the we_n low pulse in clk24 cycles (1..3).

Ports:
- clk24  in  1  system clock, 24 MHz.
- reset  in  1  asynchronous, active-high reset.
- video_slice  in  1  high = current time slot belongs to video.
- video_addr  in  16  framebuffer fetch address.
- video_req  in  1  one-cycle strobe: fetch video_addr.
- video_dq  out  8  registered byte returned to the framebuffer.
- video_valid  out  1  one-cycle strobe: video_dq updated.
- cpu_rd  in  1  CPU read request level; held until cpu_ready.
- cpu_wr  in  1  CPU write request level; held until cpu_ready.
- cpu_addr  in  16  CPU address.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  registered CPU read data.
- cpu_ready  out  1  one-cycle strobe: CPU access completed.
- sram_addr  out  16  SRAM address pins.
- sram_dq_in  in  8  SRAM data pins, read direction.
- sram_dq_out  out  8  SRAM data pins, write direction.
- sram_dq_oe  out  1  1 = drive sram_dq_out onto the pins.
- sram_oe_n  out  1  SRAM output enable, active low.
- sram_we_n  out  1  SRAM write enable, active low.

Behaviour:
- Reset values: state IDLE; sram_oe_n=1, sram_we_n=1, sram_dq_oe=0; sram_addr=0; video_dq=0, cpu_dout=0; video_valid=0, cpu_ready=0.
- FSM states: IDLE, VRD, CRD, CWS (write setup), CWP (write pulse), CWH (write hold).
- Priority in IDLE:
  - video_req high: enter VRD. This applies regardless of video_slice; a video_req outside the slice is still served.
  - else cpu_rd high and video_slice low: enter CRD.
  - else cpu_wr high and video_slice low: enter CWS.
  - cpu_rd and cpu_wr both high: the read wins.
- VRD / CRD:
  - sram_addr is loaded from the selected source on entry; sram_oe_n=0.
  - Hold for 1+RD_WAIT cycles, then sample sram_dq_in into video_dq or cpu_dout.
  - Pulse video_valid or cpu_ready for one cycle in the same edge, and return to IDLE.
  - Video latency, video_req to video_valid: 2+RD_WAIT cycles (3 at default).
- Write sequence:
  - CWS: address and data stable, sram_dq_oe=1, we_n=1, for 1 cycle.
  - CWP: we_n=0 for WR_PULSE cycles.
  - CWH: we_n=1, dq_oe still 1, for 1 cycle. Pulse cpu_ready on exit to IDLE.
- Invariants:
  - A CPU access that has started always completes; video_slice rising mid-access does not abort it.
  - video_req arriving during a CPU access is latched (single-entry pending flag) and served immediately after, in place of any new CPU request.
  - A second video_req while one is already pending overwrites the pending address; a video_overrun sticky bit is set internally (visible in simulation only).
  - sram_oe_n=0 and sram_dq_oe=1 are never true in the same cycle.
  - One cycle with both deasserted separates any read and any write.
  - sram_we_n only falls in CWP.
- The CPU may drop cpu_rd/cpu_wr only after cpu_ready. A request dropped early and already in progress still completes; cpu_ready still pulses.
- Reset asserted mid-access: all strobes go inactive asynchronously, no partial write is retried, and the pending video flag is cleared.

Decomposition:
- Shared package video_pkg: FSM state encoding, and constants RD_WAIT_DEF and WR_PULSE_DEF.
- Natural sub-module: vram_pending, the one-entry video request latch (addr + valid + overrun).
- FSM, SRAM pin registers and the countdown timer stay in vram_arbiter.

Test Plan:
- Video only: video_req with addr 0x8123, SRAM model returning 0x5A -> sram_oe_n low 2 cycles; video_valid at cycle +3 with video_dq=0x5A; cpu_ready stays 0.
- CPU write, slice low: cpu_wr, addr 0x1000, data 0xA5 -> dq_oe at +1; we_n low for exactly 2 cycles; model holds 0xA5 at 0x1000; one cpu_ready pulse after CWH.
- CPU blocked by slice: cpu_rd held while video_slice=1 for 8 cycles -> no SRAM activity; CRD starts the cycle after the slice falls; cpu_dout is correct.
- Collision: video_req issued one cycle into a CPU write -> write completes intact; VRD entered from the next IDLE; video_valid 6 cycles after the req, and a pending CPU read waits behind it.
- Back-to-back video: 4 video_req strobes 3 cycles apart (plane fetch 0x8000/A000/C000/E000) -> 4 video_valid pulses with the correct bytes; overrun never set.
- Reset mid-write: assert reset during CWP -> we_n=1 and dq_oe=0 the same cycle; after release, all outputs are at reset values and state is IDLE.
